// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants for the RV32M multiply/divide sequencer: ALU function codes,
// the sequencer state encoding used by core stall logic, and op-class helpers.
package muldiv_sequencer_pkg;

    localparam int FUNC_W = 5;

    localparam logic [FUNC_W-1:0] ALU_MUL    = 5'd10;
    localparam logic [FUNC_W-1:0] ALU_MULH   = 5'd11;
    localparam logic [FUNC_W-1:0] ALU_MULHSU = 5'd12;
    localparam logic [FUNC_W-1:0] ALU_MULHU  = 5'd13;
    localparam logic [FUNC_W-1:0] ALU_DIV    = 5'd14;
    localparam logic [FUNC_W-1:0] ALU_DIVU   = 5'd15;
    localparam logic [FUNC_W-1:0] ALU_REM    = 5'd16;
    localparam logic [FUNC_W-1:0] ALU_REMU   = 5'd17;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } md_state_e;

    function automatic logic op_is_known(input logic [FUNC_W-1:0] f);
        return f inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                         ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    function automatic logic op_is_div(input logic [FUNC_W-1:0] f);
        return f inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    function automatic logic op_is_rem(input logic [FUNC_W-1:0] f);
        return f inside {ALU_REM, ALU_REMU};
    endfunction

    function automatic logic op_a_signed(input logic [FUNC_W-1:0] f);
        return f inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    endfunction

    function automatic logic op_b_signed(input logic [FUNC_W-1:0] f);
        return f inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
    endfunction

endpackage

// File: rtl/muldiv_sequencer_step.sv
// One iteration of the shared datapath on {acc, shreg}: a radix-2 shift-add
// multiply step (LSB-first multiplier in shreg) or a restoring divide step
// (dividend shifts out of shreg, quotient bits shift in).
module muldiv_sequencer_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] shreg_i,
    input  logic [XLEN-1:0] operand_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] shreg_o
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;

    // Single add/shift or compare/subtract step; the carry of the add and the
    // bit shifted out of acc are kept in the extra top bit.
    always_comb begin
        acc_o   = acc_i;
        shreg_o = shreg_i;
        sum     = '0;
        shifted = '0;
        diff    = '0;
        if (is_div_i) begin
            shifted = {acc_i, shreg_i[XLEN-1]};
            diff    = shifted[XLEN-1:0] - operand_i;
            if (shifted >= {1'b0, operand_i}) begin
                acc_o   = diff;
                shreg_o = {shreg_i[XLEN-2:0], 1'b1};
            end else begin
                acc_o   = shifted[XLEN-1:0];
                shreg_o = {shreg_i[XLEN-2:0], 1'b0};
            end
        end else begin
            sum     = {1'b0, acc_i} + (shreg_i[0] ? {1'b0, operand_i} : {(XLEN+1){1'b0}});
            acc_o   = sum[XLEN:1];
            shreg_o = {sum[0], shreg_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M controller: works on operand magnitudes for XLEN steps of
// the shared step datapath, then applies the result sign and picks the output.
// Divide-by-zero, signed overflow and unknown codes short-cut straight to DONE.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [FUNC_W-1:0] req_function,
    input  logic [XLEN-1:0]   req_operand_a,
    input  logic [XLEN-1:0]   req_operand_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_result
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [FUNC_W-1:0] func_q, func_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]   acc_q, acc_d, shreg_q, shreg_d, op_q, op_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              neg_q, neg_d;

    logic              sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   step_acc, step_shreg;

    muldiv_sequencer_step #(.XLEN(XLEN)) u_step (
        .is_div_i  (op_is_div(func_q)),
        .acc_i     (acc_q),
        .shreg_i   (shreg_q),
        .operand_i (op_q),
        .acc_o     (step_acc),
        .shreg_o   (step_shreg)
    );

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == DONE);
    assign resp_result = result_q;

    // State, counter and datapath registers; reset discards any op in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            func_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            shreg_q  <= '0;
            op_q     <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            func_q   <= func_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            shreg_q  <= shreg_d;
            op_q     <= op_d;
            result_q <= result_d;
            neg_q    <= neg_d;
        end
    end

    // Next-state logic: accept, magnitude prep and special cases, iteration,
    // sign fixup and result hold; flush overrides everything outside IDLE.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        func_d   = func_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        shreg_d  = shreg_q;
        op_d     = op_q;
        result_d = result_q;
        neg_d    = neg_q;

        sign_a = a_q[XLEN-1] & op_a_signed(func_q);
        sign_b = b_q[XLEN-1] & op_b_signed(func_q);
        mag_a  = sign_a ? -a_q : a_q;
        mag_b  = sign_b ? -b_q : b_q;
        prod   = neg_q ? -{acc_q, shreg_q} : {acc_q, shreg_q};

        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    func_d  = req_function;
                    a_d     = req_operand_a;
                    b_d     = req_operand_b;
                    state_d = PREP;
                end
            end
            PREP: begin
                if (!op_is_known(func_q)) begin
                    result_d = '0;
                    state_d  = DONE;
                end else if (op_is_div(func_q) && (b_q == '0)) begin
                    result_d = op_is_rem(func_q) ? a_q : '1;
                    state_d  = DONE;
                end else if (op_is_div(func_q) && op_a_signed(func_q)
                             && (a_q == MIN_NEG) && (b_q == '1)) begin
                    result_d = op_is_rem(func_q) ? '0 : MIN_NEG;
                    state_d  = DONE;
                end else begin
                    acc_d   = '0;
                    count_d = CNT_W'(XLEN);
                    neg_d   = op_is_rem(func_q) ? sign_a : (sign_a ^ sign_b);
                    if (op_is_div(func_q)) begin
                        op_d    = mag_b;
                        shreg_d = mag_a;
                    end else begin
                        op_d    = mag_a;
                        shreg_d = mag_b;
                    end
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d   = step_acc;
                shreg_d = step_shreg;
                count_d = count_q - 1'b1;
                if (count_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (op_is_rem(func_q)) begin
                    result_d = neg_q ? -acc_q : acc_q;
                end else if (op_is_div(func_q)) begin
                    result_d = neg_q ? -shreg_q : shreg_q;
                end else if (func_q == ALU_MUL) begin
                    result_d = prod[XLEN-1:0];
                end else begin
                    result_d = prod[2*XLEN-1:XLEN];
                end
                state_d = DONE;
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    // Unknown function codes are a caller bug; flag them in simulation.
    known_func_a: assert property (@(posedge clock) disable iff (!reset)
        (req_valid && req_ready && !flush) |-> op_is_known(req_function));

endmodule
